// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through adapter on the read side of a non-lookahead FIFO.
// A two-entry buffer holds returned words so that one word can be delivered per cycle.
module fifo_fwft_reader #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [1:0]            count_q;
  logic                  inflight_q;
  logic                  empty_q;

  logic       pop;
  logic [2:0] occ;
  logic       slot;

  assign pop = rd && !empty_q;

  // Buffered words plus the word in flight, after this cycle's pop.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Only issue upstream when the returning word is certain to have a slot.
  assign fifo_rd = !rst && !fifo_empty && (occ < 3'd2);

  // Capture goes to index count - pop.
  assign slot = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    data_d = data_q;
    // The tail only holds a valid word when two are buffered; otherwise the head is kept.
    if (pop && (count_q == 2'd2)) begin
      data_d[0] = data_q[1];
    end
    if (inflight_q) begin
      data_d[slot] = fifo_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      data_q[0]  <= data_d[0];
      data_q[1]  <= data_d[1];
      count_q    <= occ[1:0];
      inflight_q <= fifo_rd && !fifo_empty;
      empty_q    <= (occ == 3'd0);
    end
  end

  assign empty = empty_q;
  assign dout  = data_q[0];
  assign count = count_q;

  a_count_range : assert property (@(posedge clk) disable iff (rst) occ <= 3'd2);

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Directed bench for fifo_fwft_reader with a behavioural non-lookahead FIFO upstream.
module tb_fifo_fwft_reader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          empty;
  logic [DW-1:0] dout;
  logic [1:0]    count;

  logic [DW-1:0] mem [0:2047];
  int wptr = 0;
  int rptr = 0;
  int total = 0;
  int bad = 0;

  fifo_fwft_reader #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .empty      (empty),
    .rd         (rd),
    .dout       (dout),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: data returns the cycle after an accepted read.
  assign fifo_empty = (rptr == wptr);
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_dout <= mem[rptr];
      rptr      <= rptr + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wptr] = w;
    wptr++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (fifo_rd !== 1'b0 || empty !== 1'b1 || count !== 2'd0) begin
        bad++;
        $display("FAIL idle: got fifo_rd=%b empty=%b count=%0d want 0 1 0", fifo_rd, empty, count);
      end
    end
  endtask

  task automatic test_fill;
    push(32'h5A); push(32'hF6); push(32'h09); push(32'hC4);
    #1;
    total++; if (fifo_rd !== 1'b1) begin bad++; $display("FAIL fill_rd0: got %b want 1", fifo_rd); end
    tick();
    total++;
    if (fifo_rd !== 1'b1 || empty !== 1'b1) begin
      bad++; $display("FAIL fill_t1: got fifo_rd=%b empty=%b want 1 1", fifo_rd, empty);
    end
    tick();
    total++;
    if (empty !== 1'b0 || dout !== 32'h5A || count !== 2'd1 || fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL fill_t2: got empty=%b dout=%h count=%0d fifo_rd=%b want 0 5a 1 0",
               empty, dout, count, fifo_rd);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (count !== 2'd2 || fifo_rd !== 1'b0 || dout !== 32'h5A) begin
        bad++;
        $display("FAIL fill_hold: got count=%0d fifo_rd=%b dout=%h want 2 0 5a", count, fifo_rd, dout);
      end
    end
    total++; if (rptr !== 2) begin bad++; $display("FAIL fill_reads: got %0d want 2", rptr); end
  endtask

  task automatic test_stream;
    logic [DW-1:0] exp_w [8];
    exp_w[0] = 32'h5A; exp_w[1] = 32'hF6; exp_w[2] = 32'h09; exp_w[3] = 32'hC4;
    exp_w[4] = 32'h81; exp_w[5] = 32'hE2; exp_w[6] = 32'hA0; exp_w[7] = 32'h7A;
    push(32'h81); push(32'hE2); push(32'hA0); push(32'h7A);
    rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (empty !== 1'b0 || dout !== exp_w[k]) begin
        bad++;
        $display("FAIL stream_%0d: got empty=%b dout=%h want 0 %h", k, empty, dout, exp_w[k]);
      end
      tick();
    end
    rd = 1'b0;
    total++;
    if (empty !== 1'b1 || count !== 2'd0) begin
      bad++; $display("FAIL stream_end: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_ignored_pop;
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (count !== 2'd0 || empty !== 1'b1 || dout !== 32'h7A || fifo_rd !== 1'b0) begin
        bad++;
        $display("FAIL ignored_pop: got count=%0d empty=%b dout=%h fifo_rd=%b want 0 1 7a 0",
                 count, empty, dout, fifo_rd);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_async_reset;
    push(32'h11); push(32'h22);
    tick(); tick(); tick();
    total++;
    if (count !== 2'd2 || dout !== 32'h11) begin
      bad++; $display("FAIL async_pre: got count=%0d dout=%h want 2 11", count, dout);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (count !== 2'd0 || empty !== 1'b1 || dout !== '0 || fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got count=%0d empty=%b dout=%h fifo_rd=%b want 0 1 0 0",
               count, empty, dout, fifo_rd);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (empty !== 1'b1 || fifo_rd !== 1'b0) begin
      bad++; $display("FAIL async_after: got empty=%b fifo_rd=%b want 1 0", empty, fifo_rd);
    end
  endtask

  task automatic test_reset_mid;
    push(32'h81); push(32'h33);
    #1;
    total++; if (fifo_rd !== 1'b1) begin bad++; $display("FAIL mid_issue: got %b want 1", fifo_rd); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL mid_rd_in_rst: got %b want 0", fifo_rd); end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || count !== 2'd0 || fifo_rd !== 1'b1) begin
      bad++;
      $display("FAIL mid_release: got empty=%b count=%0d fifo_rd=%b want 1 0 1", empty, count, fifo_rd);
    end
    tick();
    total++;
    if (empty !== 1'b1 || count !== 2'd0 || dout !== '0) begin
      bad++;
      $display("FAIL mid_drop: got empty=%b count=%0d dout=%h want 1 0 0", empty, count, dout);
    end
    tick();
    total++;
    if (empty !== 1'b0 || dout !== 32'h33 || count !== 2'd1) begin
      bad++;
      $display("FAIL mid_next: got empty=%b dout=%h count=%0d want 0 33 1", empty, dout, count);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total++;
    if (empty !== 1'b1 || count !== 2'd0) begin
      bad++; $display("FAIL mid_drain: got empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_backpressure;
    int idx;
    int cycles;
    idx = wptr;
    push(32'h5A); push(32'hF6); push(32'h09); push(32'hC4);
    push(32'h81); push(32'hE2); push(32'hA0); push(32'h7A);
    for (int i = 0; i < 1016; i++) push($urandom);
    cycles = 0;
    while (idx < wptr && cycles < 20000) begin
      rd = ($urandom_range(2) == 0);
      #1;
      if (rd && !empty) begin
        total++;
        if (dout !== mem[idx]) begin
          bad++; $display("FAIL bp_word_%0d: got %h want %h", idx, dout, mem[idx]);
        end
        idx++;
      end
      total++;
      if (count > 2'd2) begin bad++; $display("FAIL bp_count: got %0d want <=2", count); end
      tick();
      cycles++;
    end
    rd = 1'b0;
    total++;
    if (cycles >= 20000) begin bad++; $display("FAIL bp_timeout: got %0d cycles want <20000", cycles); end
    tick(); tick(); tick();
    total++;
    if (empty !== 1'b1 || count !== 2'd0 || rptr !== wptr) begin
      bad++;
      $display("FAIL bp_end: got empty=%b count=%0d rptr=%0d want 1 0 %0d", empty, count, rptr, wptr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_ignored_pop();
    test_async_reset();
    test_reset_mid();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
